// File: rtl/note_sequencer.sv
// note_sequencer: single-note square-wave player for the musical calculator.
// Accepts one (note, duration) request at a time, plays it for duration ticks,
// then holds a fixed silent gap before signalling completion.
`timescale 1ns / 1ps

// Test hook: shrink every half period to 4+code so tone toggling is visible
// within a short simulation.
`ifdef TB_SHORT_TABLE
`define NOTE_SEQ_SHORT_DEFAULT 1'b1
`else
`define NOTE_SEQ_SHORT_DEFAULT 1'b0
`endif

module note_sequencer #(
  parameter int unsigned TICK_DIV    = 50000,  // iclk cycles per duration tick
  parameter int unsigned GAP_MS      = 20,     // silent gap after each note, in ticks
  parameter bit          SHORT_TABLE = `NOTE_SEQ_SHORT_DEFAULT
) (
  input  logic       iclk,
  input  logic       irst_n,
  input  logic [3:0] inote,
  input  logic [7:0] idur,
  input  logic       ivalid,
  output logic       oready,
  input  logic       istop,
  output logic       otone,
  output logic       obusy,
  output logic       odone
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_GAP  = 2'b10;

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_MS * TICK_DIV - 1);

  // Half-period lookup in iclk cycles; zero marks a rest.
  function automatic logic [16:0] half_of(input logic [3:0] code);
    logic [16:0] h;
    h = '0;
    case (code)
      4'd1:    h = 17'd95556;
      4'd2:    h = 17'd90194;
      4'd3:    h = 17'd85132;
      4'd4:    h = 17'd80352;
      4'd5:    h = 17'd75843;
      4'd6:    h = 17'd71586;
      4'd7:    h = 17'd67568;
      4'd8:    h = 17'd63776;
      4'd9:    h = 17'd60197;
      4'd10:   h = 17'd56818;
      4'd11:   h = 17'd53629;
      4'd12:   h = 17'd50619;
      default: h = '0;
    endcase
    if (SHORT_TABLE && (h != '0)) begin
      h = 17'd4 + {13'd0, code};
    end
    return h;
  endfunction

  logic [1:0]  r_state;
  logic [16:0] r_half;
  logic [7:0]  r_dur;
  logic [16:0] r_tone_cnt;
  logic [7:0]  r_tick_cnt;
  logic [31:0] r_presc;
  logic [31:0] r_gap_cnt;
  logic        r_tone;
  logic        r_done;

  logic [1:0]  w_next_state;
  logic        w_accept;
  logic        w_rest;
  logic        w_tick;
  logic        w_play_end;
  logic        w_gap_end;
  logic        w_tone_wrap;
  logic        w_stay_play;
  logic        w_stay_gap;

  assign w_accept    = (r_state == S_IDLE) && ivalid && !istop;
  assign w_rest      = (r_half == '0);
  assign w_tick      = (r_presc == TICK_LAST);
  assign w_play_end  = (r_dur == 8'd0) || (w_tick && ((r_tick_cnt + 8'd1) == r_dur));
  assign w_gap_end   = (r_gap_cnt == GAP_LAST);
  assign w_tone_wrap = (r_tone_cnt == (r_half - 17'd1));
  assign w_stay_play = (r_state == S_PLAY) && (w_next_state == S_PLAY);
  assign w_stay_gap  = (r_state == S_GAP) && (w_next_state == S_GAP);

  // Next-state selection; istop overrides every other transition while busy.
  always_comb begin
    // NOTE: a default assignment up front keeps every path covered, so no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_PLAY;
      S_PLAY: begin
        if (istop)           w_next_state = S_IDLE;
        else if (w_play_end) w_next_state = S_GAP;
      end
      S_GAP: begin
        if (istop || w_gap_end) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iclk or negedge irst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!irst_n) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Latch the looked-up half period and the duration on the accept edge.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_half <= '0;
      r_dur  <= '0;
    end else if (w_accept) begin
      r_half <= half_of(inote);
      r_dur  <= idur;
    end
  end

  // Tone counter, tick prescaler and tick count run only while PLAY continues.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_tone_cnt <= '0;
      r_presc    <= '0;
      r_tick_cnt <= '0;
    end else if (w_stay_play) begin
      r_tone_cnt <= w_tone_wrap ? 17'd0 : r_tone_cnt + 17'd1;
      r_presc    <= w_tick ? 32'd0 : r_presc + 32'd1;
      if (w_tick) r_tick_cnt <= r_tick_cnt + 8'd1;
    end else begin
      r_tone_cnt <= '0;
      r_presc    <= '0;
      r_tick_cnt <= '0;
    end
  end

  // Gap counter runs only while GAP continues.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n)         r_gap_cnt <= '0;
    else if (w_stay_gap) r_gap_cnt <= r_gap_cnt + 32'd1;
    else                 r_gap_cnt <= '0;
  end

  // Square wave: toggle at each half-period wrap, forced low outside PLAY and on rests.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_tone <= 1'b0;
    end else if (w_stay_play) begin
      if (w_tone_wrap && !w_rest) r_tone <= ~r_tone;
    end else begin
      r_tone <= 1'b0;
    end
  end

  // Completion pulse on a natural GAP->IDLE exit only.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) r_done <= 1'b0;
    else         r_done <= (r_state == S_GAP) && !istop && w_gap_end;
  end

  assign oready = (r_state == S_IDLE);
  assign obusy  = (r_state == S_PLAY) || (r_state == S_GAP);
  assign otone  = r_tone;
  assign odone  = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: two instances (real and shortened
// half-period tables) share stimulus and are compared every cycle against an
// elapsed-time model of each note's play/gap timeline.
`timescale 1ns / 1ps

module tb_note_sequencer;

  localparam int TICK = 10;
  localparam int GAP  = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] inote;
  logic [7:0] idur;
  logic       ivalid;
  logic       istop;

  logic ready_r, tone_r, busy_r, done_r;
  logic ready_s, tone_s, busy_s, done_s;

  int n_cmp;
  int n_fail;

  int real_half [0:15] = '{0, 95556, 90194, 85132, 80352, 75843, 71586, 67568,
                           63776, 60197, 56818, 53629, 50619, 0, 0, 0};

  note_sequencer #(.TICK_DIV(TICK), .GAP_MS(GAP), .SHORT_TABLE(1'b0)) u_real (
    .iclk(clk), .irst_n(rst_n), .inote(inote), .idur(idur), .ivalid(ivalid),
    .oready(ready_r), .istop(istop), .otone(tone_r), .obusy(busy_r), .odone(done_r)
  );

  note_sequencer #(.TICK_DIV(TICK), .GAP_MS(GAP), .SHORT_TABLE(1'b1)) u_short (
    .iclk(clk), .irst_n(rst_n), .inote(inote), .idur(idur), .ivalid(ivalid),
    .oready(ready_s), .istop(istop), .otone(tone_s), .obusy(busy_s), .odone(done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A job is described by the number of edges elapsed since its accept edge.
  bit m_active;
  int m_k;
  int m_play;
  int m_total;
  int m_half_r;
  int m_half_s;
  bit m_rest;

  task automatic model_step();
    if (m_active && (m_k < m_total)) begin
      if (istop) m_active = 1'b0;
      else       m_k = m_k + 1;
    end else begin
      m_active = 1'b0;
      if (ivalid && !istop) begin
        m_active = 1'b1;
        m_k      = 0;
        m_rest   = (inote == 4'd0) || (inote > 4'd12);
        m_half_r = real_half[inote];
        m_half_s = 4 + int'(inote);
        m_play   = (idur == 8'd0) ? 1 : int'(idur) * TICK;
        m_total  = m_play + GAP * TICK;
      end
    end
  endtask

  function automatic int exp_busy();
    return (m_active && (m_k < m_total)) ? 1 : 0;
  endfunction

  function automatic int exp_done();
    return (m_active && (m_k == m_total)) ? 1 : 0;
  endfunction

  function automatic int exp_tone(input int half);
    if (exp_busy() == 0 || m_rest || m_k >= m_play || half == 0) return 0;
    return ((m_k / half) % 2);
  endfunction

  initial begin
    m_active = 1'b0;
    m_k = 0; m_play = 0; m_total = 0; m_half_r = 0; m_half_s = 0; m_rest = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_active = 1'b0;
      else        model_step();
    end
  end

  // Every-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("ready_real", int'(ready_r), 1 - exp_busy());
      check("busy_real",  int'(busy_r),  exp_busy());
      check("done_real",  int'(done_r),  exp_done());
      check("tone_real",  int'(tone_r),  exp_tone(m_half_r));
      check("ready_short", int'(ready_s), 1 - exp_busy());
      check("busy_short",  int'(busy_s),  exp_busy());
      check("done_short",  int'(done_s),  exp_done());
      check("tone_short",  int'(tone_s),  exp_tone(m_half_s));
    end
  end

  // ---------------- directed helpers ----------------
  // Call between the accept edge and its falling edge; reports the index of the
  // falling edge (0 = right after accept) where odone shows, and tone rises.
  task automatic wait_done(output int done_at, output int rises_s, output int rises_r);
    logic prev_s, prev_r;
    done_at = -1; rises_s = 0; rises_r = 0; prev_s = 1'b0; prev_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tone_s && !prev_s) rises_s++;
      if (tone_r && !prev_r) rises_r++;
      prev_s = tone_s;
      prev_r = tone_r;
      if (done_r) begin
        done_at = i;
        break;
      end
    end
  endtask

  // Start from a falling edge with the block idle.
  task automatic run_note(input logic [3:0] note, input logic [7:0] dur,
                          output int done_at, output int rises_s, output int rises_r);
    inote = note; idur = dur; ivalid = 1'b1;
    @(posedge clk);
    #1 ivalid = 1'b0;
    wait_done(done_at, rises_s, rises_r);
  endtask

  int d_at, r_s, r_r;
  bit seen;

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; inote = '0; idur = '0; ivalid = 1'b0; istop = 1'b0;

    // 1. reset state
    #12;
    check("rst_tone",  int'(tone_r),  0);
    check("rst_ready", int'(ready_r), 1);
    check("rst_busy",  int'(busy_r),  0);
    check("rst_done",  int'(done_r),  0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'(ready_s), 1);

    // 2. note 10 for 3 ticks: 30-cycle silent PLAY (real table), 20-cycle gap
    run_note(4'd10, 8'd3, d_at, r_s, r_r);
    check("t2_done_at", d_at, 50);
    check("t2_real_rises", r_r, 0);
    check("t2_short_rises", r_s, 1);

    // 3. short table, note 1 (half 5), 2 ticks: rises at 5 and 15
    run_note(4'd1, 8'd2, d_at, r_s, r_r);
    check("t3_done_at", d_at, 40);
    check("t3_short_rises", r_s, 2);

    // 4. rest for 5 ticks
    run_note(4'd0, 8'd5, d_at, r_s, r_r);
    check("t4_done_at", d_at, 70);
    check("t4_short_rises", r_s, 0);

    // zero duration: one PLAY cycle then the gap
    run_note(4'd5, 8'd0, d_at, r_s, r_r);
    check("dur0_done_at", d_at, 21);
    check("dur0_short_rises", r_s, 0);

    // istop together with ivalid in IDLE: not accepted
    inote = 4'd2; idur = 8'd1; ivalid = 1'b1; istop = 1'b1;
    @(posedge clk);
    #1 ivalid = 1'b0; istop = 1'b0;
    @(negedge clk);
    check("idle_stop_ready", int'(ready_r), 1);
    check("idle_stop_busy",  int'(busy_r),  0);

    // 5. istop at cycle 7 of PLAY with ivalid held high
    inote = 4'd3; idur = 8'd4; ivalid = 1'b1;
    @(posedge clk);               // accept edge
    repeat (6) @(posedge clk);
    #1 istop = 1'b1;
    @(posedge clk);               // abort edge
    #1 istop = 1'b0;
    @(negedge clk);
    check("stop_ready", int'(ready_r), 1);
    check("stop_busy",  int'(busy_r),  0);
    check("stop_tone",  int'(tone_s),  0);
    check("stop_done",  int'(done_r),  0);
    @(posedge clk);               // held request re-accepted
    #1 ivalid = 1'b0;
    wait_done(d_at, r_s, r_r);
    check("stop_reaccept_done_at", d_at, 60);

    // 6. async reset while the tone is high
    inote = 4'd1; idur = 8'd5; ivalid = 1'b1;
    @(posedge clk);
    #1 ivalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tone_s) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_tone_high_seen", int'(seen), 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_tone", int'(tone_s), 0);
    check("t6_async_busy", int'(busy_s), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("t6_release_ready", int'(ready_s), 1);
    check("t6_release_busy",  int'(busy_s),  0);

    // randomized traffic, checked every cycle by the model comparison
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk);
      #1;
      istop = ($urandom_range(0, 79) == 0);
      if (ivalid) begin
        if ($urandom_range(0, 5) == 0) ivalid = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        inote  = 4'($urandom_range(0, 15));
        idur   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
        ivalid = 1'b1;
      end
    end
    ivalid = 1'b0; istop = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
